// File: rtl/regfile_wb_queue_if.sv
// Writeback queue bus: load/ALU result handshakes, register-file write port and pending-write lookup.
// master = producer/consumer side, slave = regfile_wb_queue.
interface regfile_wb_queue_if #(
    parameter int ASIZE = 5,
    parameter int DSIZE = 32
);
    logic             mem_valid;
    logic             mem_ready;
    logic [ASIZE-1:0] mem_waddr;
    logic [DSIZE-1:0] mem_wdata;
    logic             alu_valid;
    logic             alu_ready;
    logic [ASIZE-1:0] alu_waddr;
    logic [DSIZE-1:0] alu_wdata;
    logic             wen;
    logic [ASIZE-1:0] waddr;
    logic [DSIZE-1:0] wdata;
    logic [ASIZE-1:0] qaddr;
    logic             qhit;
    logic             busy;

    modport master (
        output mem_valid, mem_waddr, mem_wdata,
        output alu_valid, alu_waddr, alu_wdata,
        output qaddr,
        input  mem_ready, alu_ready,
        input  wen, waddr, wdata,
        input  qhit, busy
    );

    modport slave (
        input  mem_valid, mem_waddr, mem_wdata,
        input  alu_valid, alu_waddr, alu_wdata,
        input  qaddr,
        output mem_ready, alu_ready,
        output wen, waddr, wdata,
        output qhit, busy
    );
endinterface

// File: rtl/regfile_wb_queue.sv
// In-order DEPTH-entry writeback FIFO (loads before ALU, r0 dropped), draining one write per cycle; mem write 1 cycle after accept, ALU alongside it 2.
// Readies come from the registered free count only; `REGFILE_WB_BYPASS_EN` lets an accepted write skip an empty FIFO in the same cycle.
module regfile_wb_queue #(
    parameter int ASIZE = 5,
    parameter int DSIZE = 32,
    parameter int DEPTH = 4
) (
    input  logic               clk,
    input  logic               rst,
    regfile_wb_queue_if.slave  bus
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [ASIZE-1:0] q_addr [DEPTH];
    logic [DSIZE-1:0] q_data [DEPTH];
    logic [PW-1:0]    rd_ptr;
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    alu_slot;
    logic [PW-1:0]    off;
    logic [CW-1:0]    count;
    logic [CW-1:0]    count_nxt;
    logic [CW-1:0]    free;
    logic [1:0]       n_enq;

    logic mem_rdy, alu_rdy;
    logic mem_acc, alu_acc;
    logic mem_live, alu_live;
    logic byp_mem, byp_alu;
    logic enq_mem, enq_alu;
    logic deq;
    logic hit;

    logic             wen_c;
    logic [ASIZE-1:0] waddr_c;
    logic [DSIZE-1:0] wdata_c;

    // Free space is taken from the registered count so a same-cycle pop never widens acceptance.
    assign free    = CW'(DEPTH) - count;
    assign mem_rdy = !rst && (free != '0);
    assign alu_rdy = !rst && ((free >= CW'(2)) || ((free != '0) && !bus.mem_valid));

    assign mem_acc  = bus.mem_valid && mem_rdy;
    assign alu_acc  = bus.alu_valid && alu_rdy;
    assign mem_live = mem_acc && (bus.mem_waddr != '0);
    assign alu_live = alu_acc && (bus.alu_waddr != '0);
    assign deq      = (count != '0);

`ifdef REGFILE_WB_BYPASS_EN
    // Only the older write may bypass; a concurrent ALU result queues behind it.
    assign byp_mem = (count == '0) && mem_live;
    assign byp_alu = (count == '0) && alu_live && !mem_live;
`else
    assign byp_mem = 1'b0;
    assign byp_alu = 1'b0;
`endif

    assign enq_mem   = mem_live && !byp_mem;
    assign enq_alu   = alu_live && !byp_alu;
    assign n_enq     = {1'b0, enq_mem} + {1'b0, enq_alu};
    assign alu_slot  = wr_ptr + PW'(enq_mem);
    assign count_nxt = count + CW'(n_enq) - CW'(deq);

    always_comb begin
        wen_c   = 1'b0;
        waddr_c = '0;
        wdata_c = '0;
        if (!rst) begin
            if (byp_mem) begin
                wen_c   = 1'b1;
                waddr_c = bus.mem_waddr;
                wdata_c = bus.mem_wdata;
            end else if (byp_alu) begin
                wen_c   = 1'b1;
                waddr_c = bus.alu_waddr;
                wdata_c = bus.alu_wdata;
            end else begin
                wen_c   = deq;
                waddr_c = q_addr[rd_ptr];
                wdata_c = q_data[rd_ptr];
            end
        end
    end

    // An entry is live when its distance from the head is below count; the head itself counts.
    always_comb begin
        hit = 1'b0;
        off = '0;
        for (int i = 0; i < DEPTH; i++) begin
            off = PW'(i) - rd_ptr;
            if ((CW'(off) < count) && (q_addr[i] == bus.qaddr)) begin
                hit = 1'b1;
            end
        end
    end

    assign bus.mem_ready = mem_rdy;
    assign bus.alu_ready = alu_rdy;
    assign bus.wen       = wen_c;
    assign bus.waddr     = waddr_c;
    assign bus.wdata     = wdata_c;
    assign bus.qhit      = !rst && hit && (bus.qaddr != '0);
    assign bus.busy      = !rst && deq;

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                q_addr[i] <= '0;
                q_data[i] <= '0;
            end
        end else begin
            if (enq_mem) begin
                q_addr[wr_ptr] <= bus.mem_waddr;
                q_data[wr_ptr] <= bus.mem_wdata;
            end
            if (enq_alu) begin
                q_addr[alu_slot] <= bus.alu_waddr;
                q_data[alu_slot] <= bus.alu_wdata;
            end
            wr_ptr <= wr_ptr + PW'(n_enq);
            if (deq) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            count <= count_nxt;
        end
    end
endmodule

// File: tb/tb_regfile_wb_queue.sv
// Directed bench for regfile_wb_queue: reset, latency, ordering, r0 drop, qhit, streaming and mid-run reset.
// Expectations follow the default build, or the bypass build when REGFILE_WB_BYPASS_EN is defined.
module tb_regfile_wb_queue;
`ifdef REGFILE_WB_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic clk;
    logic rst;
    int   n_tests = 0;
    int   n_fail  = 0;

    regfile_wb_queue_if #(.ASIZE(5), .DSIZE(32)) bus ();

    regfile_wb_queue #(.ASIZE(5), .DSIZE(32), .DEPTH(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.mem_valid = 1'b0;
        bus.alu_valid = 1'b0;
    endtask

    task automatic drive_mem(input logic [4:0] a, input logic [31:0] d);
        bus.mem_valid = 1'b1;
        bus.mem_waddr = a;
        bus.mem_wdata = d;
    endtask

    task automatic drive_alu(input logic [4:0] a, input logic [31:0] d);
        bus.alu_valid = 1'b1;
        bus.alu_waddr = a;
        bus.alu_wdata = d;
    endtask

    logic [36:0] sb[$];
    int          mi, ai, cnt, fr;
    logic        emr, ear, macc, aacc, bm, ba, ew;
    logic [36:0] expd;

    initial begin
        rst = 1'b1;
        idle();
        bus.mem_waddr = '0; bus.mem_wdata = '0;
        bus.alu_waddr = '0; bus.alu_wdata = '0;
        bus.qaddr     = '0;
        tick();
        tick();

        // Reset: readies and outputs forced low even with valids up
        drive_mem(5'd3, 32'h1);
        drive_alu(5'd4, 32'h2);
        bus.qaddr = 5'd3;
        #3;
        check("rst_mrdy", bus.mem_ready, 0);
        check("rst_ardy", bus.alu_ready, 0);
        check("rst_wen", bus.wen, 0);
        check("rst_busy", bus.busy, 0);
        check("rst_qhit", bus.qhit, 0);
        tick();
        rst = 1'b0;
        idle();
        #3;
        check("post_wen", bus.wen, 0);
        check("post_waddr", bus.waddr, 0);
        check("post_wdata", bus.wdata, 0);
        check("post_busy", bus.busy, 0);
        check("post_qhit", bus.qhit, 0);
        check("post_mrdy", bus.mem_ready, 1);
        check("post_ardy", bus.alu_ready, 1);
        tick();

`ifdef REGFILE_WB_BYPASS_EN
        // Single load bypasses the empty FIFO
        drive_mem(5'd2, 32'h5);
        #3;
        check("t1_wen0", bus.wen, 1);
        check("t1_addr0", bus.waddr, 2);
        check("t1_data0", bus.wdata, 32'h5);
        check("t1_busy0", bus.busy, 0);
        tick();
        idle();
        #3;
        check("t1_wen1", bus.wen, 0);
        check("t1_busy1", bus.busy, 0);
        tick();

        // Both sources: mem bypasses, ALU follows next cycle
        drive_mem(5'd4, 32'h11);
        drive_alu(5'd5, 32'h22);
        #3;
        check("t2_mrdy", bus.mem_ready, 1);
        check("t2_ardy", bus.alu_ready, 1);
        check("t2_addr0", bus.waddr, 4);
        check("t2_data0", bus.wdata, 32'h11);
        tick();
        idle();
        #3;
        check("t2_wen1", bus.wen, 1);
        check("t2_addr1", bus.waddr, 5);
        check("t2_data1", bus.wdata, 32'h22);
        tick();
        #3;
        check("t2_wen2", bus.wen, 0);
        tick();
`else
        // Single load: written the cycle after acceptance
        drive_mem(5'd3, 32'hA5);
        #3;
        check("t1_mrdy", bus.mem_ready, 1);
        check("t1_wen0", bus.wen, 0);
        tick();
        idle();
        #3;
        check("t1_wen1", bus.wen, 1);
        check("t1_addr1", bus.waddr, 3);
        check("t1_data1", bus.wdata, 32'hA5);
        check("t1_busy1", bus.busy, 1);
        tick();
        #3;
        check("t1_wen2", bus.wen, 0);
        check("t1_busy2", bus.busy, 0);
        tick();

        // Both sources in one cycle: load first, then ALU
        drive_mem(5'd4, 32'h11);
        drive_alu(5'd5, 32'h22);
        #3;
        check("t2_mrdy", bus.mem_ready, 1);
        check("t2_ardy", bus.alu_ready, 1);
        check("t2_wen0", bus.wen, 0);
        tick();
        idle();
        #3;
        check("t2_wen1", bus.wen, 1);
        check("t2_addr1", bus.waddr, 4);
        check("t2_data1", bus.wdata, 32'h11);
        tick();
        #3;
        check("t2_wen2", bus.wen, 1);
        check("t2_addr2", bus.waddr, 5);
        check("t2_data2", bus.wdata, 32'h22);
        tick();
        #3;
        check("t2_wen3", bus.wen, 0);
        tick();
`endif

        // ALU write to r0 is consumed and dropped
        drive_alu(5'd0, 32'h99);
        #3;
        check("t3_ardy", bus.alu_ready, 1);
        check("t3_wen0", bus.wen, 0);
        tick();
        idle();
        #3;
        check("t3_wen1", bus.wen, 0);
        check("t3_busy1", bus.busy, 0);
        tick();
        #3;
        check("t3_wen2", bus.wen, 0);
        check("t3_busy2", bus.busy, 0);
        tick();

        // Pending-write lookup on r7
        drive_mem(5'd6, 32'h66);
        drive_alu(5'd7, 32'h77);
        bus.qaddr = 5'd7;
        #3;
        check("q_pre", bus.qhit, 0);
        tick();
        idle();
`ifdef REGFILE_WB_BYPASS_EN
        #3;
        check("q_head_addr", bus.waddr, 7);
        check("q_head_hit", bus.qhit, 1);
        bus.qaddr = 5'd0;
        #1;
        check("q_r0", bus.qhit, 0);
        bus.qaddr = 5'd7;
        tick();
        #3;
        check("q_after", bus.qhit, 0);
`else
        #3;
        check("q_queued", bus.qhit, 1);
        bus.qaddr = 5'd0;
        #1;
        check("q_r0", bus.qhit, 0);
        bus.qaddr = 5'd7;
        tick();
        #3;
        check("q_head_addr", bus.waddr, 7);
        check("q_head_hit", bus.qhit, 1);
        tick();
        #3;
        check("q_after", bus.qhit, 0);
`endif
        tick();

        // Streaming: both sources valid until 8 items each are taken
        mi = 0;
        ai = 0;
        sb.delete();
        for (int c = 0; c < 40; c++) begin
            bus.mem_valid = (mi < 8);
            bus.mem_waddr = 5'(8 + mi);
            bus.mem_wdata = 32'h100 + mi;
            bus.alu_valid = (ai < 8);
            bus.alu_waddr = 5'(16 + ai);
            bus.alu_wdata = 32'h200 + ai;
            #3;
            cnt  = sb.size();
            fr   = 4 - cnt;
            emr  = (fr >= 1);
            ear  = (fr >= 2) || ((fr >= 1) && !bus.mem_valid);
            check("s_mrdy", bus.mem_ready, emr);
            check("s_ardy", bus.alu_ready, ear);
            macc = bus.mem_valid && emr;
            aacc = bus.alu_valid && ear;
            bm   = BYP && (cnt == 0) && macc;
            ba   = BYP && (cnt == 0) && aacc && !macc;
            ew   = 1'b1;
            expd = '0;
            if (cnt != 0)  expd = sb[0];
            else if (bm)   expd = {bus.mem_waddr, bus.mem_wdata};
            else if (ba)   expd = {bus.alu_waddr, bus.alu_wdata};
            else           ew = 1'b0;
            check("s_wen", bus.wen, ew);
            if (ew) check("s_write", {bus.waddr, bus.wdata}, expd);
            tick();
            if (cnt != 0) void'(sb.pop_front());
            if (macc && !bm) sb.push_back({bus.mem_waddr, bus.mem_wdata});
            if (aacc && !ba) sb.push_back({bus.alu_waddr, bus.alu_wdata});
            if (macc) mi++;
            if (aacc) ai++;
        end
        idle();
        check("s_mem_taken", mi, 8);
        check("s_alu_taken", ai, 8);
        check("s_drained", sb.size(), 0);
        #3;
        check("s_idle_wen", bus.wen, 0);
        tick();

        // Reset with entries queued discards them
        drive_mem(5'd9, 32'h9);
        drive_alu(5'd10, 32'hA);
        tick();
        #3;
        check("mr_busy", bus.busy, 1);
        tick();
        rst = 1'b1;
        idle();
        bus.qaddr = 5'd10;
        #3;
        check("mr_wen_rst", bus.wen, 0);
        check("mr_busy_rst", bus.busy, 0);
        check("mr_mrdy_rst", bus.mem_ready, 0);
        tick();
        rst = 1'b0;
        #3;
        check("mr_wen_after", bus.wen, 0);
        check("mr_busy_after", bus.busy, 0);
        check("mr_qhit_after", bus.qhit, 0);
        check("mr_waddr_after", bus.waddr, 0);
        tick();
        #3;
        check("mr_wen_later", bus.wen, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
